// File: rtl/dmem_responder_if.sv
// Load/store bus between the mips core (master) and the data-memory responder (slave).
interface dmem_responder_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] ALUOut;
    logic [DATA_W-1:0] rd2_Data;
    logic [DATA_W-1:0] ReadData;
    logic              mem_stall;

    modport master (
        output MemRead, MemWrite, ALUOut, rd2_Data,
        input  ReadData, mem_stall
    );

    modport slave (
        input  MemRead, MemWrite, ALUOut, rd2_Data,
        output ReadData, mem_stall
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: sync-read RAM with one-stall loads and saturating statistics.
// Macro DMEM_RDCACHE_EN adds a one-entry last-read cache so repeated loads need no stall.
module dmem_responder #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [CNT_W-1:0] load_cnt,
    output logic [CNT_W-1:0] store_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             protocol_err
);
    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_reg;
    logic              protocol_err_reg;

    logic              ram_we, ram_re;
    logic              load_inc, store_inc, err_set;
    logic              stall;
    logic [DATA_W-1:0] read_data;
    logic              cache_hit;
    logic [DATA_W-1:0] cache_rd_data;

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.MemRead && !bus.MemWrite && !cache_hit) state_next = RD_WAIT;
            RD_WAIT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A store always wins over a simultaneous load; in RD_WAIT any store is dropped.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        load_inc  = 1'b0;
        store_inc = 1'b0;
        err_set   = 1'b0;
        stall     = 1'b0;
        read_data = '0;
        if (rst) begin
            case (state_reg)
                IDLE: begin
                    if (bus.MemWrite) begin
                        ram_we    = 1'b1;
                        store_inc = 1'b1;
                        err_set   = bus.MemRead;
                    end else if (bus.MemRead) begin
                        if (cache_hit) begin
                            read_data = cache_rd_data;
                            load_inc  = 1'b1;
                        end else begin
                            stall  = 1'b1;
                            ram_re = 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    err_set = bus.MemWrite;
                    if (bus.MemRead) begin
                        read_data = rd_data_reg;
                        load_inc  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ReadData  = read_data;
    assign bus.mem_stall = stall;

    always_ff @(posedge clk) begin
        if (ram_we) mem[bus.ALUOut] <= bus.rd2_Data;
        if (ram_re) rd_data_reg <= mem[bus.ALUOut];
    end

`ifdef DMEM_RDCACHE_EN
    logic              cache_valid_reg;
    logic [ADDR_W-1:0] cache_tag_reg;
    logic [DATA_W-1:0] cache_data_reg;
    logic              cache_fill;

    assign cache_fill    = (state_reg == RD_WAIT) && load_inc;
    assign cache_hit     = cache_valid_reg && (cache_tag_reg == bus.ALUOut);
    assign cache_rd_data = cache_data_reg;

    // Write-through on tag match keeps the cached copy coherent with the RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_valid_reg <= 1'b0;
        end else if (cache_fill) begin
            cache_valid_reg <= 1'b1;
            cache_tag_reg   <= bus.ALUOut;
            cache_data_reg  <= rd_data_reg;
        end else if (ram_we && (cache_tag_reg == bus.ALUOut)) begin
            cache_data_reg  <= bus.rd2_Data;
        end
    end
`else
    assign cache_hit     = 1'b0;
    assign cache_rd_data = '0;
`endif

    logic [2:0] cnt_inc;
    assign cnt_inc = {stall, store_inc, load_inc};

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (!rst)                              cnt_reg <= '0;
            else if (cnt_inc[gi] && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign load_cnt  = g_cnt[0].cnt_reg;
    assign store_cnt = g_cnt[1].cnt_reg;
    assign stall_cnt = g_cnt[2].cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst)         protocol_err_reg <= 1'b0;
        else if (err_set) protocol_err_reg <= 1'b1;
    end

    assign protocol_err = protocol_err_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder, checked against a transaction-level memory model.
module tb_dmem_responder;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef DMEM_RDCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] load_cnt, store_cnt, stall_cnt;
    logic             protocol_err;

    dmem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    dmem_responder #(.DATA_W(8), .ADDR_W(8), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .load_cnt     (load_cnt),
        .store_cnt    (store_cnt),
        .stall_cnt    (stall_cnt),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, which address the last completed load left cached, totals.
    bit [7:0] m_mem [256];
    bit       m_cv;
    bit [7:0] m_ctag;
    int       m_load, m_store, m_stall;
    bit       m_err;

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input bit r, input bit w, input bit [7:0] a, input bit [7:0] d);
        bus.MemRead  = r;
        bus.MemWrite = w;
        bus.ALUOut   = a;
        bus.rd2_Data = d;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_load_cnt"},  32'(load_cnt),  32'(sat(m_load)));
        chk({tag, "_store_cnt"}, 32'(store_cnt), 32'(sat(m_store)));
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(sat(m_stall)));
        chk({tag, "_perr"},      32'(protocol_err), 32'(m_err));
        $display("txn %s: load=%0d store=%0d stall=%0d perr=%0b", tag, load_cnt, store_cnt, stall_cnt, protocol_err);
    endtask

    task automatic model_reset();
        m_cv = 1'b0; m_load = 0; m_store = 0; m_stall = 0; m_err = 1'b0;
    endtask

    task automatic do_reset(input int cycles, input bit read_last, input bit [7:0] a);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            set_bus(read_last && (i == cycles - 1), 1'b0, a, 8'h00);
            #1;
            chk("rst_stall", 32'(bus.mem_stall), 32'd0);
            chk("rst_rdata", 32'(bus.ReadData), 32'd0);
            step();
        end
        rst = 1'b1;
        set_bus(1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        chk_cnt("reset");
    endtask

    task automatic do_store(input bit [7:0] a, input bit [7:0] d, input bit with_read);
        set_bus(with_read, 1'b1, a, d);
        #1;
        chk("st_stall", 32'(bus.mem_stall), 32'd0);
        chk("st_rdata", 32'(bus.ReadData), 32'd0);
        step();
        m_mem[a] = d;
        m_store++;
        if (with_read) m_err = 1'b1;
        chk_cnt(with_read ? "store+load" : "store");
    endtask

    task automatic do_load(input bit [7:0] a, input bit bad_write);
        set_bus(1'b1, 1'b0, a, 8'h00);
        #1;
        if (CACHE_EN && m_cv && m_ctag == a) begin
            chk("hit_stall", 32'(bus.mem_stall), 32'd0);
            chk("hit_rdata", 32'(bus.ReadData), 32'(m_mem[a]));
            step();
            m_load++;
        end else begin
            chk("miss_stall", 32'(bus.mem_stall), 32'd1);
            chk("miss_rdata", 32'(bus.ReadData), 32'd0);
            step();
            m_stall++;
            if (bad_write) begin
                bus.MemWrite = 1'b1;
                bus.rd2_Data = ~m_mem[a];
                m_err = 1'b1;
            end
            #1;
            chk("wait_stall", 32'(bus.mem_stall), 32'd0);
            chk("wait_rdata", 32'(bus.ReadData), 32'(m_mem[a]));
            step();
            m_load++;
            m_cv = 1'b1;
            m_ctag = a;
        end
        chk_cnt(bad_write ? "load+badwr" : "load");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        set_bus(1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        #1;

        do_reset(2, 1'b1, 8'h10);

        do_store(8'h10, 8'hAA, 1'b0);
        do_load(8'h10, 1'b0);
        chk("first_load_cnt",  32'(load_cnt),  32'd1);
        chk("first_stall_cnt", 32'(stall_cnt), 32'd1);

        do_load(8'h10, 1'b0);
        do_store(8'h10, 8'hBB, 1'b0);
        do_load(8'h10, 1'b0);

        do_store(8'h20, 8'hCC, 1'b1);
        chk("both_perr", 32'(protocol_err), 32'd1);
        do_load(8'h20, 1'b0);

        // Abort a miss at 0x30 (never loaded, so never cached).
        set_bus(1'b1, 1'b0, 8'h30, 8'h00);
        #1;
        chk("abort_miss_stall", 32'(bus.mem_stall), 32'd1);
        step();
        m_stall++;
        set_bus(1'b0, 1'b0, 8'h30, 8'h00);
        #1;
        chk("abort_stall", 32'(bus.mem_stall), 32'd0);
        chk("abort_rdata", 32'(bus.ReadData), 32'd0);
        step();
        chk_cnt("abort");

        // Reset asserted while in RD_WAIT.
        set_bus(1'b1, 1'b0, 8'h30, 8'h00);
        #1;
        chk("rstmid_miss_stall", 32'(bus.mem_stall), 32'd1);
        step();
        m_stall++;
        do_reset(1, 1'b1, 8'h30);
        do_load(8'h10, 1'b0);

        do_reset(1, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) do_store(8'(8'h50 + i), 8'($urandom), 1'b0);
        chk("store_sat", 32'(store_cnt), 32'(CMAX));

        do_reset(1, 1'b0, 8'h00);
        for (int a = 8'h40; a < 8'h48; a++) do_store(8'(a), 8'($urandom), 1'b0);
        for (int n = 0; n < 80; n++) begin
            bit [7:0] a;
            a = 8'(8'h40 + $urandom_range(0, 7));
            if (n % 10 == 9) do_reset(1, 1'($urandom), a);
            case ($urandom_range(0, 4))
                0, 1:    do_load(a, 1'b0);
                2:       do_store(a, 8'($urandom), 1'b0);
                3:       do_store(a, 8'($urandom), 1'b1);
                default: do_load(a, 1'b1);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the `mips` core's load/store interface.
- Receives the core's address (`ALUOut`), write data (`rd2_Data`), `MemWrite` and a `MemRead` strobe, and returns `ReadData`.
- Backing store is a synchronous-read RAM, so a load normally costs one stall cycle.
- A one-entry last-read cache lets repeated loads to the same address complete with no stall.
- Also keeps saturating load/store/stall counters and a sticky protocol-error flag for bench and debug use.

## Interface
- `DATA_W`, 8, data width (matches core datapath)
- `ADDR_W`, 8, address width; array depth is 2^ADDR_W
- `CNT_W`, 16, width of each statistics counter
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (reset when `rst`=0 at a rising edge)
- `MemRead`  in  1  load request; address held stable while `mem_stall`=1
- `MemWrite`  in  1  store request
- `ALUOut`  in  ADDR_W  load/store address
- `rd2_Data`  in  DATA_W  store data
- `ReadData`  out  DATA_W  load data; 0x00 when no load completes this cycle
- `mem_stall`  out  1  core must freeze PC and hold request
- `load_cnt`  out  CNT_W  completed loads
- `store_cnt`  out  CNT_W  accepted stores
- `stall_cnt`  out  CNT_W  cycles with `mem_stall`=1
- `protocol_err`  out  1  sticky; an illegal request was seen

## Operation
- **FSM states:** IDLE and RD_WAIT.
- **Cache:** one entry, holding {valid, tag[ADDR_W], data[DATA_W]}.
- **IDLE, MemRead=1, MemWrite=0, cache hit** (valid and tag==`ALUOut`):
  - `ReadData` = cached data, driven combinationally.
  - `mem_stall`=0; `load_cnt`+1; stay in IDLE.
- **IDLE, MemRead=1, MemWrite=0, miss:**
  - `mem_stall`=1 combinationally.
  - RAM read of `ALUOut` is issued at this edge; go to RD_WAIT.
- **RD_WAIT, MemRead=1:**
  - `ReadData` = RAM output; `mem_stall`=0.
  - Cache is loaded with {1, `ALUOut`, data}; `load_cnt`+1; return to IDLE.
- **RD_WAIT, MemRead=0:** the load is aborted. Return to IDLE, no count, `ReadData`=0x00.
- **IDLE, MemWrite=1, MemRead=0:**
  - RAM[`ALUOut`] ← `rd2_Data` at the edge; `store_cnt`+1.
  - If the cache tag matches, cache data is updated to the same value (write-through, stays coherent).
- **MemWrite=1 and MemRead=1 together:** the store executes, the load is ignored (no stall, `ReadData`=0x00), and `protocol_err` is set.
- **MemWrite=1 in RD_WAIT:** the write is ignored and `protocol_err` is set; RD_WAIT completes normally.
- **Counters:** all three saturate at 2^CNT_W−1 and never wrap.
- **Reset** (`rst`=0 at an edge):
  - FSM returns to IDLE, including from RD_WAIT; any pending load is dropped and not counted.
  - Cache valid cleared; all counters 0; `protocol_err` 0.
  - While `rst`=0, `mem_stall` and `ReadData` are forced to 0.
  - RAM contents are not reset.

## Timing
- Load hit: 0 stall cycles; data valid in the same cycle as `MemRead`.
- Load miss: exactly 1 stall cycle; data valid in the cycle after `MemRead` first rises, in state RD_WAIT.
- Store: posted at the rising edge of its cycle; a load of the same address in the next cycle returns the new value, via cache if the tag matched, otherwise via RAM with 1 stall.
- `stall_cnt` increments at every edge where `mem_stall`=1.
- `protocol_err` is visible the cycle after the offending edge.
- All outputs except `ReadData`/`mem_stall` are registered.

## Configuration
- Macro: `DMEM_RDCACHE_EN`.
- **Defined:** the last-read cache is present; hits complete with 0 stall cycles as described above.
- **Undefined:** no cache state exists, and every load takes the miss path (1 stall cycle). Store, counter and error behaviour are unchanged.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles, with `MemRead`=1 asserted in the second → `mem_stall`=0, `ReadData`=0x00, all counters 0, `protocol_err`=0.
- **Store then load:** store 0xAA to 0x10, then load 0x10 → 1 stall cycle, `ReadData`=0xAA in RD_WAIT, `load_cnt`=1, `store_cnt`=1, `stall_cnt`=1.
- **Repeat load, then coherence:**
  - Repeat load of 0x10 → with `DMEM_RDCACHE_EN`, 0 stalls and 0xAA; without it, 1 stall and 0xAA.
  - Then store 0xBB to 0x10 and load 0x10 → 0xBB.
- **Simultaneous request:** `MemRead`=`MemWrite`=1 at 0x20 with data 0xCC → no stall, `ReadData`=0x00, `protocol_err`=1 next cycle; a subsequent load of 0x20 returns 0xCC.
- **Abort and reset mid-load:**
  - Miss at 0x30, then `MemRead`=0 in RD_WAIT → IDLE, `load_cnt` unchanged.
  - Repeat the miss and assert `rst`=0 in RD_WAIT → IDLE, counters 0.
- **Saturation:** with CNT_W=4, issue 20 stores → `store_cnt`=15 and stays at 15.
